// File: rtl/encode_ctrl.sv
// encode_ctrl: runs one threshold-compare/shift encoder through a NUM_STEPS-step
// conversion per request and returns the captured code word with its popcount.
module encode_ctrl #(
    parameter int NUM_STEPS = 8,
    parameter int DATA_W    = 8
) (
    input  logic                               CLK100MHZ,
    input  logic                               reset,
    input  logic                               in_valid,
    output logic                               in_ready,
    input  logic [DATA_W-1:0]                  in_data,
    input  logic [DATA_W-1:0]                  thr_base,
    input  logic [DATA_W-1:0]                  thr_step,
    input  logic                               abort,
    output logic [DATA_W-1:0]                  enc_data,
    output logic [DATA_W-1:0]                  enc_delay,
    output logic                               enc_start,
    output logic                               enc_reset,
    input  logic [NUM_STEPS-1:0]               enc_encoded,
    output logic                               out_valid,
    input  logic                               out_ready,
    output logic [NUM_STEPS-1:0]               out_code,
    output logic [$clog2(NUM_STEPS + 1)-1:0]   out_ones
);

    localparam int ONES_W = $clog2(NUM_STEPS + 1);
    localparam int CNT_W  = $clog2(NUM_STEPS + 1);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        CLEAR   = 3'd1,
        RUN     = 3'd2,
        CAPTURE = 3'd3,
        DONE    = 3'd4
    } state_t;

    state_t                state_r, state_s;
    logic                  hold_r, hold_s;
    logic [DATA_W-1:0]     sample_r, sample_s;
    logic [DATA_W-1:0]     base_r, base_s;
    logic [DATA_W-1:0]     step_r, step_s;
    logic [DATA_W-1:0]     acc_r, acc_s;
    logic [CNT_W-1:0]      cnt_r, cnt_s;
    logic [DATA_W-1:0]     data_r, data_s;
    logic                  start_r, start_s;
    logic                  enc_reset_r, enc_reset_s;
    logic [NUM_STEPS-1:0]  code_r, code_s;
    logic [ONES_W-1:0]     ones_r, ones_s;

    function automatic logic [DATA_W-1:0] sat_add(input logic [DATA_W-1:0] a,
                                                  input logic [DATA_W-1:0] b);
        logic [DATA_W:0] sum;
        sum = {1'b0, a} + {1'b0, b};
        return sum[DATA_W] ? {DATA_W{1'b1}} : sum[DATA_W-1:0];
    endfunction

    function automatic logic [ONES_W-1:0] popcount(input logic [NUM_STEPS-1:0] v);
        logic [ONES_W-1:0] n;
        n = {ONES_W{1'b0}};
        for (int i = 0; i < NUM_STEPS; i++) begin
            n = n + ONES_W'(v[i]);
        end
        return n;
    endfunction

    // hold_r masks in_ready for the one cycle the encoder is being reset after abort/reset
    assign in_ready  = (state_r == IDLE) && !hold_r;
    assign out_valid = (state_r == DONE);
    assign enc_data  = data_r;
    assign enc_delay = acc_r;
    assign enc_start = start_r;
    assign enc_reset = enc_reset_r;
    assign out_code  = code_r;
    assign out_ones  = ones_r;

    // Next-state and next registered-output decode
    always_comb begin
        state_s     = state_r;
        hold_s      = 1'b0;
        sample_s    = sample_r;
        base_s      = base_r;
        step_s      = step_r;
        acc_s       = {DATA_W{1'b0}};
        cnt_s       = cnt_r;
        data_s      = {DATA_W{1'b0}};
        start_s     = 1'b0;
        enc_reset_s = 1'b0;
        code_s      = code_r;
        ones_s      = ones_r;
        case (state_r)
            IDLE: begin
                if (in_valid && in_ready) begin
                    state_s     = CLEAR;
                    sample_s    = in_data;
                    base_s      = thr_base;
                    step_s      = thr_step;
                    data_s      = in_data;
                    enc_reset_s = 1'b1;
                end else begin
                    state_s = IDLE;
                end
            end
            CLEAR: begin
                if (abort) begin
                    state_s     = IDLE;
                    hold_s      = 1'b1;
                    enc_reset_s = 1'b1;
                end else begin
                    state_s = RUN;
                    cnt_s   = {CNT_W{1'b0}};
                    acc_s   = base_r;
                    start_s = 1'b1;
                    data_s  = sample_r;
                end
            end
            RUN: begin
                if (abort) begin
                    state_s     = IDLE;
                    hold_s      = 1'b1;
                    enc_reset_s = 1'b1;
                end else begin
                    data_s = sample_r;
                    cnt_s  = cnt_r + CNT_W'(1);
                    if (cnt_r == CNT_W'(NUM_STEPS - 1)) begin
                        state_s = CAPTURE;
                    end else begin
                        acc_s   = sat_add(acc_r, step_r);
                        start_s = 1'b1;
                    end
                end
            end
            CAPTURE: begin
                if (abort) begin
                    state_s     = IDLE;
                    hold_s      = 1'b1;
                    enc_reset_s = 1'b1;
                end else begin
                    state_s = DONE;
                    code_s  = enc_encoded;
                    ones_s  = popcount(enc_encoded);
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_s = IDLE;
                end else begin
                    state_s = DONE;
                end
            end
            default: begin
                state_s = IDLE;
            end
        endcase
    end

    // State and registered outputs, synchronous active-low reset
    always_ff @(posedge CLK100MHZ) begin
        if (!reset) begin
            state_r     <= IDLE;
            hold_r      <= 1'b1;
            sample_r    <= {DATA_W{1'b0}};
            base_r      <= {DATA_W{1'b0}};
            step_r      <= {DATA_W{1'b0}};
            acc_r       <= {DATA_W{1'b0}};
            cnt_r       <= {CNT_W{1'b0}};
            data_r      <= {DATA_W{1'b0}};
            start_r     <= 1'b0;
            enc_reset_r <= 1'b1;
            code_r      <= {NUM_STEPS{1'b0}};
            ones_r      <= {ONES_W{1'b0}};
        end else begin
            state_r     <= state_s;
            hold_r      <= hold_s;
            sample_r    <= sample_s;
            base_r      <= base_s;
            step_r      <= step_s;
            acc_r       <= acc_s;
            cnt_r       <= cnt_s;
            data_r      <= data_s;
            start_r     <= start_s;
            enc_reset_r <= enc_reset_s;
            code_r      <= code_s;
            ones_r      <= ones_s;
        end
    end

endmodule

// File: tb/tb_encode_ctrl.sv
// tb_encode_ctrl: encode_ctrl with a behavioural encoder, a timeline reference
// model checked every cycle, and directed literal cases from the test plan.
module tb_encode_ctrl;

    logic       CLK100MHZ = 1'b0;
    logic       reset = 1'b0, in_valid = 1'b0, abort = 1'b0, out_ready = 1'b0;
    logic [7:0] in_data = 8'h00, thr_base = 8'h00, thr_step = 8'h00;
    logic       in_ready, enc_start, enc_reset, out_valid;
    logic [7:0] enc_data, enc_delay, enc_encoded, out_code;
    logic [3:0] out_ones;

    int checks = 0;
    int errors = 0;
    bit chk_en = 1'b0;
    logic [7:0] dly_seen [8];
    int t_res [3];

    always #5 CLK100MHZ = ~CLK100MHZ;

    encode_ctrl #(.NUM_STEPS(8), .DATA_W(8)) dut (
        .CLK100MHZ(CLK100MHZ), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .thr_base(thr_base), .thr_step(thr_step),
        .abort(abort),
        .enc_data(enc_data), .enc_delay(enc_delay), .enc_start(enc_start),
        .enc_reset(enc_reset), .enc_encoded(enc_encoded),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_code(out_code), .out_ones(out_ones)
    );

    // Encoder: shifts in (data >= delay) each started cycle, first compare ends in bit 7
    logic [7:0] enc_q;
    assign enc_encoded = enc_q;
    always @(posedge CLK100MHZ) begin
        if (enc_reset === 1'b1) enc_q <= 8'h00;
        else if (enc_start === 1'b1) enc_q <= {enc_q[6:0], (enc_data >= enc_delay)};
    end

    function automatic int thr(input int b, input int s, input int i);
        int t;
        t = b + i * s;
        return (t > 255) ? 255 : t;
    endfunction

    function automatic int ref_code(input int d, input int b, input int s);
        int c;
        c = 0;
        for (int i = 0; i < 8; i++) if (d >= thr(b, s, i)) c = c | (1 << (7 - i));
        return c;
    endfunction

    function automatic int ones_of(input int c);
        int n;
        n = 0;
        for (int i = 0; i < 8; i++) n = n + ((c >> i) & 1);
        return n;
    endfunction

    task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: m_k counts cycles since accept (-1 = no request), m_hold = encoder-reset cycle
    int         m_k = -1;
    bit         m_hold = 1'b1;
    logic [7:0] m_data = 8'h00, m_base = 8'h00, m_step = 8'h00, m_code = 8'h00;
    int         m_ones = 0;
    wire        m_run = (m_k >= 2) && (m_k <= 9);

    always @(posedge CLK100MHZ) begin
        if (!reset) begin
            m_k <= -1; m_hold <= 1'b1; m_code <= 8'h00; m_ones <= 0;
        end else begin
            m_hold <= 1'b0;
            if (m_k < 0) begin
                if (in_valid && !m_hold) begin
                    m_k <= 1; m_data <= in_data; m_base <= thr_base; m_step <= thr_step;
                end
            end else if (m_k <= 10 && abort) begin
                m_k <= -1; m_hold <= 1'b1;
            end else if (m_k == 10) begin
                m_code <= 8'(ref_code(m_data, m_base, m_step));
                m_ones <= ones_of(ref_code(m_data, m_base, m_step));
                m_k <= 11;
            end else if (m_k >= 11) begin
                if (out_ready) m_k <= -1;
            end else begin
                m_k <= m_k + 1;
            end
        end
    end

    // Per-cycle comparison of every DUT output against the model
    always @(negedge CLK100MHZ) begin
        if (chk_en) begin
            cmp("in_ready",  in_ready,  (m_k < 0) && !m_hold);
            cmp("out_valid", out_valid, m_k >= 11);
            cmp("enc_reset", enc_reset, (m_k == 1) || m_hold);
            cmp("enc_start", enc_start, m_run);
            cmp("enc_delay", enc_delay, m_run ? thr(m_base, m_step, m_k - 2) : 0);
            cmp("enc_data",  enc_data,  (m_k >= 1 && m_k <= 10) ? m_data : 8'h00);
            cmp("out_code",  out_code,  m_code);
            cmp("out_ones",  out_ones,  m_ones);
        end
    end

    task automatic wait_ready();
        int n;
        n = 0;
        while (in_ready !== 1'b1 && n < 40) begin
            @(negedge CLK100MHZ);
            n++;
        end
        cmp("ready_timeout", in_ready, 1);
    endtask

    task automatic run_req(input logic [7:0] d, input logic [7:0] b, input logic [7:0] s,
                           input logic [7:0] lit_code, input logic [3:0] lit_ones, input int bp);
        int lat;
        wait_ready();
        in_valid = 1'b1; in_data = d; thr_base = b; thr_step = s;
        @(negedge CLK100MHZ);
        in_valid = 1'b0; in_data = 8'($urandom); thr_base = 8'($urandom); thr_step = 8'($urandom);
        lat = 1;
        while (out_valid !== 1'b1 && lat < 30) begin
            if (lat >= 2 && lat <= 9) dly_seen[lat-2] = enc_delay;
            @(negedge CLK100MHZ);
            lat++;
        end
        cmp("latency", lat, 11);
        cmp("code_lit", out_code, lit_code);
        cmp("ones_lit", out_ones, lit_ones);
        for (int i = 0; i < bp; i++) begin
            @(negedge CLK100MHZ);
            cmp("bp_valid", out_valid, 1);
            cmp("bp_code", out_code, lit_code);
            cmp("bp_ready", in_ready, 0);
        end
        out_ready = 1'b1;
        @(negedge CLK100MHZ);
        out_ready = 1'b0;
    endtask

    initial begin
        int n, nres;
        repeat (3) @(negedge CLK100MHZ);
        chk_en = 1'b1;
        cmp("rst_in_ready", in_ready, 0);
        cmp("rst_out_valid", out_valid, 0);
        cmp("rst_enc_reset", enc_reset, 1);
        cmp("rst_out_code", out_code, 0);
        cmp("rst_enc_start", enc_start, 0);
        reset = 1'b1;
        @(negedge CLK100MHZ);
        cmp("rst_release_ready", in_ready, 1);
        cmp("rst_release_enc_reset", enc_reset, 0);

        run_req(8'h80, 8'h10, 8'h20, 8'hF0, 4'd4, 5);
        run_req(8'hFF, 8'hF0, 8'h10, 8'hFF, 4'd8, 0);
        cmp("sat_dly0", dly_seen[0], 8'hF0);
        for (int i = 1; i < 8; i++) cmp("sat_dly", dly_seen[i], 8'hFF);
        run_req(8'hF5, 8'hF0, 8'h10, 8'h80, 4'd1, 0);
        run_req(8'h40, 8'h40, 8'h00, 8'hFF, 4'd8, 0);
        run_req(8'h00, 8'h01, 8'h00, 8'h00, 4'd0, 0);

        // Abort in the third RUN cycle (T4)
        wait_ready();
        in_valid = 1'b1; in_data = 8'h80; thr_base = 8'h10; thr_step = 8'h20;
        @(negedge CLK100MHZ);
        in_valid = 1'b0;
        repeat (3) @(negedge CLK100MHZ);
        abort = 1'b1;
        @(negedge CLK100MHZ);
        abort = 1'b0;
        cmp("abort_enc_reset", enc_reset, 1);
        cmp("abort_ready_k1", in_ready, 0);
        @(negedge CLK100MHZ);
        cmp("abort_ready_k2", in_ready, 1);
        repeat (12) begin
            @(negedge CLK100MHZ);
            cmp("abort_no_valid", out_valid, 0);
        end
        run_req(8'h80, 8'h10, 8'h20, 8'hF0, 4'd4, 0);

        // Reset low for two cycles from the fifth RUN cycle (T6)
        wait_ready();
        in_valid = 1'b1; in_data = 8'hFF; thr_base = 8'h00; thr_step = 8'h00;
        @(negedge CLK100MHZ);
        in_valid = 1'b0;
        repeat (5) @(negedge CLK100MHZ);
        reset = 1'b0;
        @(negedge CLK100MHZ);
        cmp("rmid_enc_reset", enc_reset, 1);
        cmp("rmid_enc_start", enc_start, 0);
        cmp("rmid_enc_delay", enc_delay, 0);
        cmp("rmid_enc_data", enc_data, 0);
        cmp("rmid_out_code", out_code, 0);
        cmp("rmid_out_ones", out_ones, 0);
        cmp("rmid_in_ready", in_ready, 0);
        cmp("rmid_out_valid", out_valid, 0);
        @(negedge CLK100MHZ);
        reset = 1'b1;
        @(negedge CLK100MHZ);
        cmp("rmid_release_ready", in_ready, 1);
        run_req(8'h55, 8'h00, 8'h20, 8'hE0, 4'd3, 0);

        // Back-to-back with in_valid and out_ready held high
        wait_ready();
        in_valid = 1'b1; in_data = 8'h80; thr_base = 8'h10; thr_step = 8'h20; out_ready = 1'b1;
        n = 0; nres = 0;
        while (nres < 3 && n < 60) begin
            @(negedge CLK100MHZ);
            n++;
            if (out_valid === 1'b1) begin
                t_res[nres] = n;
                nres++;
            end
        end
        in_valid = 1'b0; out_ready = 1'b0;
        cmp("b2b_count", nres, 3);
        cmp("b2b_first", t_res[0], 11);
        cmp("b2b_gap1", t_res[1] - t_res[0], 12);
        cmp("b2b_gap2", t_res[2] - t_res[1], 12);

        // Randomized traffic with occasional abort and reset
        for (int c = 0; c < 1500; c++) begin
            @(negedge CLK100MHZ);
            reset     = ($urandom_range(0, 99) != 0);
            abort     = ($urandom_range(0, 24) == 0);
            in_valid  = 1'($urandom_range(0, 1));
            out_ready = ($urandom_range(0, 2) != 0);
            in_data   = 8'($urandom);
            thr_base  = 8'($urandom);
            thr_step  = (($urandom_range(0, 3) == 0) ? 8'h00 : 8'($urandom_range(0, 64)));
        end
        @(negedge CLK100MHZ);
        reset = 1'b1; abort = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        repeat (20) @(negedge CLK100MHZ);
        chk_en = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

endmodule
